// File: rtl/obstacle_spawner_pkg.sv
// Shared game definitions: FSM encoding, screen constants, slot index width.
package obstacle_spawner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_CHECK,
    ST_REQ,
    ST_WRITE
  } state_e;

  // Shared with the renderer.
  localparam int unsigned SCREEN_H = 768;
  localparam int unsigned START_Y  = 0;
  localparam int unsigned COORD_W  = 10;

  // Width of a slot index; at least one bit even for tiny tables.
  function automatic int unsigned slot_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/obstacle_spawner_if.sv
// Spawner-facing signal bundle: generator handshake, hit input, renderer read port.
interface obstacle_spawner_if #(
  parameter int unsigned NUM_SLOTS = 4
);
  localparam int unsigned SW = obstacle_spawner_pkg::slot_idx_w(NUM_SLOTS);

  logic          frame_tick;
  logic          rand_new;
  logic          rand_offset;
  logic [9:0]    rand_data;
  logic          hit_valid;
  logic [SW-1:0] hit_slot;
  logic [SW-1:0] rd_slot;
  logic          rd_valid;
  logic [9:0]    rd_x;
  logic [9:0]    rd_y;
  logic          miss;
  logic [7:0]    spawn_count;
  logic          busy;

  modport master (
    input  frame_tick, rand_data, hit_valid, hit_slot, rd_slot,
    output rand_new, rand_offset, rd_valid, rd_x, rd_y, miss, spawn_count, busy
  );

  modport slave (
    output frame_tick, rand_data, hit_valid, hit_slot, rd_slot,
    input  rand_new, rand_offset, rd_valid, rd_x, rd_y, miss, spawn_count, busy
  );

endinterface

// File: rtl/obstacle_spawner_table.sv
// Obstacle slot storage: one write port, a hit-clear port, two combinational reads.
module obstacle_table
  import obstacle_spawner_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SW        = slot_idx_w(NUM_SLOTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [SW-1:0]        wr_idx_i,
  input  logic                 wr_valid_i,
  input  logic [9:0]           wr_x_i,
  input  logic [9:0]           wr_y_i,
  input  logic                 hit_valid_i,
  input  logic [SW-1:0]        hit_slot_i,
  input  logic [SW-1:0]        mv_idx_i,
  output logic                 mv_valid_o,
  output logic [9:0]           mv_x_o,
  output logic [9:0]           mv_y_o,
  input  logic [SW-1:0]        rd_idx_i,
  output logic                 rd_valid_o,
  output logic [9:0]           rd_x_o,
  output logic [9:0]           rd_y_o,
  output logic [NUM_SLOTS-1:0] valid_o
);

  logic [NUM_SLOTS-1:0] valid_q;
  logic [9:0]           x_q [NUM_SLOTS];
  logic [9:0]           y_q [NUM_SLOTS];

  // Slot registers; a same-slot write overrides a hit so a fresh spawn survives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      if (hit_valid_i && !(wr_en_i && (wr_idx_i == hit_slot_i)))
        valid_q[hit_slot_i] <= 1'b0;
      if (wr_en_i) begin
        valid_q[wr_idx_i] <= wr_valid_i;
        x_q[wr_idx_i]     <= wr_x_i;
        y_q[wr_idx_i]     <= wr_y_i;
      end
    end
  end

  assign mv_valid_o = valid_q[mv_idx_i];
  assign mv_x_o     = x_q[mv_idx_i];
  assign mv_y_o     = y_q[mv_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_x_o     = x_q[rd_idx_i];
  assign rd_y_o     = y_q[rd_idx_i];
  assign valid_o    = valid_q;

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: per-frame move/retire pass, interval-scheduled spawns.
module obstacle_spawner #(
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned SPAWN_INTERVAL = 60,
  parameter int unsigned SPEED          = 4,
  parameter int unsigned SCREEN_H       = obstacle_spawner_pkg::SCREEN_H,
  parameter int unsigned START_Y        = obstacle_spawner_pkg::START_Y
) (
  input  logic               clock,
  input  logic               reset_n,
  obstacle_spawner_if.master bus
);
  import obstacle_spawner_pkg::*;

  localparam int unsigned SW = slot_idx_w(NUM_SLOTS);

  state_e        state_q, state_d;
  logic [SW-1:0] idx_q, idx_d;
  logic [SW-1:0] lat_q, lat_d;
  logic [7:0]    interval_q, interval_d;
  logic [7:0]    spawn_q, spawn_d;
  logic          pend_q, pend_d;
  logic [9:0]    xlat_q, xlat_d;

  logic                 wr_en, wr_valid;
  logic [SW-1:0]        wr_idx;
  logic [9:0]           wr_x, wr_y;
  logic                 mv_valid;
  logic [9:0]           mv_x, mv_y;
  logic [NUM_SLOTS-1:0] valid_vec;
  logic                 free_found;
  logic [SW-1:0]        free_idx;
  logic [10:0]          y_sum;
  logic                 rand_new, miss;

  obstacle_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .SW        (SW)
  ) u_table (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .wr_en_i     (wr_en),
    .wr_idx_i    (wr_idx),
    .wr_valid_i  (wr_valid),
    .wr_x_i      (wr_x),
    .wr_y_i      (wr_y),
    .hit_valid_i (bus.hit_valid),
    .hit_slot_i  (bus.hit_slot),
    .mv_idx_i    (idx_q),
    .mv_valid_o  (mv_valid),
    .mv_x_o      (mv_x),
    .mv_y_o      (mv_y),
    .rd_idx_i    (bus.rd_slot),
    .rd_valid_o  (bus.rd_valid),
    .rd_x_o      (bus.rd_x),
    .rd_y_o      (bus.rd_y),
    .valid_o     (valid_vec)
  );

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned k = NUM_SLOTS; k > 0; k--) begin
      if (!valid_vec[k-1]) begin
        free_found = 1'b1;
        free_idx   = SW'(k - 1);
      end
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      lat_q      <= '0;
      interval_q <= 8'(SPAWN_INTERVAL);
      spawn_q    <= '0;
      pend_q     <= 1'b0;
      xlat_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      interval_q <= interval_d;
      spawn_q    <= spawn_d;
      pend_q     <= pend_d;
      xlat_q     <= xlat_d;
    end
  end

  // Next-state, table write port and pulse outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    interval_d = interval_q;
    spawn_d    = spawn_q;
    pend_d     = pend_q;
    xlat_d     = xlat_q;
    wr_en      = 1'b0;
    wr_idx     = idx_q;
    wr_valid   = 1'b0;
    wr_x       = mv_x;
    wr_y       = mv_y;
    y_sum      = '0;
    rand_new   = 1'b0;
    miss       = 1'b0;

    if (bus.frame_tick && (state_q != ST_IDLE))
      pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_tick || pend_q) begin
          pend_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        // A hit on this slot suppresses the move entirely: no y update, no miss.
        if (mv_valid && !(bus.hit_valid && (bus.hit_slot == idx_q))) begin
          wr_en = 1'b1;
          y_sum = {1'b0, mv_y} + 11'(SPEED);
          if (y_sum >= 11'(SCREEN_H)) begin
            wr_valid = 1'b0;
            miss     = 1'b1;
          end else begin
            wr_valid = 1'b1;
            wr_y     = y_sum[9:0];
          end
        end
        if (idx_q == SW'(NUM_SLOTS - 1))
          state_d = ST_CHECK;
        else
          idx_d = idx_q + 1'b1;
      end
      ST_CHECK: begin
        if (interval_q == 8'd1) begin
          interval_d = 8'(SPAWN_INTERVAL);
          if (free_found) begin
            lat_d   = free_idx;
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          interval_d = interval_q - 8'd1;
          state_d    = ST_IDLE;
        end
      end
      ST_REQ: begin
        rand_new = 1'b1;
        xlat_d   = bus.rand_data;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en    = 1'b1;
        wr_idx   = lat_q;
        wr_valid = 1'b1;
        wr_x     = xlat_q;
        wr_y     = 10'(START_Y);
        spawn_d  = spawn_q + 8'd1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rand_new    = rand_new;
  assign bus.rand_offset = spawn_q[0];
  assign bus.miss        = miss;
  assign bus.spawn_count = spawn_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: default instance plus a fast-spawn instance.
module tb_obstacle_spawner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obstacle_spawner_if #(.NUM_SLOTS(4)) ba ();
  obstacle_spawner_if #(.NUM_SLOTS(4)) bb ();

  obstacle_spawner #(
    .NUM_SLOTS(4), .SPAWN_INTERVAL(60), .SPEED(4), .SCREEN_H(768), .START_Y(0)
  ) dut_a (.clock(clk), .reset_n(rst_n), .bus(ba));

  obstacle_spawner #(
    .NUM_SLOTS(4), .SPAWN_INTERVAL(2), .SPEED(1), .SCREEN_H(768), .START_Y(0)
  ) dut_b (.clock(clk), .reset_n(rst_n), .bus(bb));

  int n_checks = 0;
  int n_errors = 0;
  int rn_a = 0, rn_b = 0, miss_a = 0, pass_a = 0;
  logic off_a = 1'b0;
  logic busy_prev = 1'b0;

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (ba.rand_new) begin
      rn_a++;
      off_a = ba.rand_offset;
    end
    if (bb.rand_new) rn_b++;
    if (ba.miss) miss_a++;
    if (ba.busy && !busy_prev) pass_a++;
    busy_prev = ba.busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ba.busy || bb.busy) && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic tick();
    step();
    ba.frame_tick = 1'b1;
    bb.frame_tick = 1'b1;
    step();
    ba.frame_tick = 1'b0;
    bb.frame_tick = 1'b0;
    wait_idle();
  endtask

  task automatic slot_a(input string tag, input int s, input int v, input int x, input int y);
    step();
    ba.rd_slot = 2'(s);
    #1;
    check({tag, "_v"}, 32'(ba.rd_valid), v);
    if (x >= 0) check({tag, "_x"}, 32'(ba.rd_x), x);
    if (y >= 0) check({tag, "_y"}, 32'(ba.rd_y), y);
  endtask

  task automatic slot_b(input string tag, input int s, input int v, input int x, input int y);
    step();
    bb.rd_slot = 2'(s);
    #1;
    check({tag, "_v"}, 32'(bb.rd_valid), v);
    if (x >= 0) check({tag, "_x"}, 32'(bb.rd_x), x);
    if (y >= 0) check({tag, "_y"}, 32'(bb.rd_y), y);
  endtask

  int t = 0;
  int snap;
  bit seen;

  initial begin
    ba.frame_tick = 0; ba.rand_data = 10'd200; ba.hit_valid = 0; ba.hit_slot = '0; ba.rd_slot = '0;
    bb.frame_tick = 0; bb.rand_data = 10'd77;  bb.hit_valid = 0; bb.hit_slot = '0; bb.rd_slot = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_busy", 32'(ba.busy), 0);
    check("rst_spawn_count", 32'(ba.spawn_count), 0);
    check("rst_rand_new", 32'(ba.rand_new), 0);
    check("rst_miss", 32'(ba.miss), 0);
    slot_a("rst_s0", 0, 0, 0, 0);
    slot_a("rst_s3", 3, 0, 0, 0);

    // Fast instance: fill all slots, then a skipped spawn at tick 10
    repeat (10) tick();
    check("b_full_rand_new", 32'(rn_b), 4);
    check("b_full_spawn_count", 32'(bb.spawn_count), 4);
    slot_b("b_s3", 3, 1, 77, 2);
    step();
    bb.hit_valid = 1'b1;
    bb.hit_slot  = 2'd1;
    step();
    bb.hit_valid = 1'b0;
    slot_b("b_hit_s1", 1, 0, -1, -1);
    // Interval must have reloaded to 2 at the skip: spawn lands on tick 12
    tick();
    check("b_no_spawn_t11", 32'(rn_b), 4);
    tick();
    check("b_reload_spawn", 32'(rn_b), 5);
    check("b_spawn_count5", 32'(bb.spawn_count), 5);
    slot_b("b_s1_new", 1, 1, 77, 0);
    slot_b("b_s0", 0, 1, 77, 10);

    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // First spawn after 60 ticks
    repeat (59) begin tick(); t++; end
    check("no_spawn_t59", 32'(rn_a), 0);
    tick(); t++;
    check("spawn_t60_rand_new", 32'(rn_a), 1);
    check("spawn_t60_offset", 32'(off_a), 0);
    check("spawn_t60_count", 32'(ba.spawn_count), 1);
    slot_a("t60_s0", 0, 1, 200, 0);

    repeat (10) begin tick(); t++; end
    slot_a("t70_s0", 0, 1, 200, 40);
    check("t70_no_miss", 32'(miss_a), 0);

    while (t < 120) begin tick(); t++; end
    check("t120_offset", 32'(off_a), 1);
    check("t120_count", 32'(ba.spawn_count), 2);

    // Off-screen retirement
    while (t < 251) begin tick(); t++; end
    slot_a("t251_s0", 0, 1, 200, 764);
    slot_a("t251_s3", 3, 1, 200, 44);
    check("t251_count", 32'(ba.spawn_count), 4);
    check("t251_no_miss", 32'(miss_a), 0);
    snap = miss_a;
    tick(); t++;
    check("t252_miss_once", 32'(miss_a - snap), 1);
    slot_a("t252_s0", 0, 0, -1, 764);

    ba.rand_data = 10'd513;
    while (t < 300) begin tick(); t++; end
    slot_a("t300_s0", 0, 1, 513, 0);
    check("t300_count", 32'(ba.spawn_count), 5);

    // Hit on slot 0 in the cycle MOVE handles slot 0
    snap = miss_a;
    step();
    ba.frame_tick = 1'b1; bb.frame_tick = 1'b1;
    step();
    ba.frame_tick = 1'b0; bb.frame_tick = 1'b0;
    ba.hit_valid = 1'b1;
    ba.hit_slot  = 2'd0;
    step();
    ba.hit_valid = 1'b0;
    wait_idle();
    t++;
    slot_a("hit_s0", 0, 0, -1, 0);
    check("hit_no_miss", 32'(miss_a - snap), 0);
    slot_a("t301_s2", 2, 1, -1, 484);

    // Pending tick: three ticks, two while busy, gives exactly two passes
    snap = pass_a;
    step();
    ba.frame_tick = 1'b1; bb.frame_tick = 1'b1;
    step();
    ba.frame_tick = 1'b0; bb.frame_tick = 1'b0;
    step();
    ba.frame_tick = 1'b1; bb.frame_tick = 1'b1;
    step();
    step();
    ba.frame_tick = 1'b0; bb.frame_tick = 1'b0;
    repeat (40) step();
    t += 2;
    check("pending_passes", 32'(pass_a - snap), 2);
    slot_a("pending_s2", 2, 1, -1, 492);

    // Reset asserted during REQ
    while (t < 359) begin tick(); t++; end
    step();
    ba.frame_tick = 1'b1; bb.frame_tick = 1'b1;
    step();
    ba.frame_tick = 1'b0; bb.frame_tick = 1'b0;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (ba.rand_new) seen = 1;
      else step();
    end
    check("req_reached", 32'(seen), 1);
    rst_n = 1'b0;
    #1;
    check("rst_req_rand_new", 32'(ba.rand_new), 0);
    check("rst_req_busy", 32'(ba.busy), 0);
    check("rst_req_count", 32'(ba.spawn_count), 0);
    for (int s = 0; s < 4; s++) slot_a("rst_req_slot", s, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
- Consumes the 10-bit pseudo-random generator output and turns it into falling game obstacles.
- Keeps a table of NUM_SLOTS obstacles: x from the generator, y advanced every frame.
- Schedules spawns on a frame-count interval, retires obstacles that leave the screen or are hit, and exposes a read port to the renderer.
- Sits between the random generator (upstream) and the sprite/collision logic (downstream).

Parameters:
- NUM_SLOTS, 4: obstacle table depth; power of two, 2..8.
- SPAWN_INTERVAL, 60: frames between spawn attempts, including the first after reset; must be 1..255.
- SPEED, 4: pixels added to y per frame.
- SCREEN_H, 768: y value at or beyond which an obstacle retires.
- START_Y, 0: y of a newly spawned obstacle.

Ports:
- clock, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- frame_tick, input, 1: one-cycle pulse per video frame.
- rand_new, output, 1: request to the generator; high for exactly one cycle per spawn.
- rand_offset, output, 1: offset select passed to the generator; equals the low bit of spawn_count.
- rand_data, input, 10: generator output; valid during the cycle rand_new is high.
- hit_valid, input, 1: one-cycle pulse meaning obstacle hit_slot was hit.
- hit_slot, input, log2(NUM_SLOTS): slot that was hit.
- rd_slot, input, log2(NUM_SLOTS): renderer read address.
- rd_valid, output, 1: slot occupied (combinational read).
- rd_x, output, 10: slot x (combinational read).
- rd_y, output, 10: slot y (combinational read).
- miss, output, 1: one-cycle pulse when an obstacle retires off-screen.
- spawn_count, output, 8: wrapping count of successful spawns.
- busy, output, 1: FSM not in IDLE.

Behaviour:
- Reset (async assert, sync deassert):
  - every slot valid=0, x=0, y=0
  - interval counter = SPAWN_INTERVAL
  - spawn_count=0, tick_pending=0
  - rand_new=0, miss=0, FSM=IDLE
- FSM states: IDLE, MOVE, CHECK, REQ, WRITE.
- IDLE: on frame_tick or tick_pending, clear tick_pending, set slot index i=0, go to MOVE.
- MOVE: one slot per cycle, for i=0..NUM_SLOTS-1. For a valid slot, compute y+SPEED in 11 bits:
  - if the result is >= SCREEN_H: clear valid and pulse miss for that cycle.
  - otherwise: y <= y+SPEED.
  - After the last slot, go to CHECK.
- CHECK: decrement the interval counter.
  - If it reaches 0: reload SPAWN_INTERVAL.
    - If a free slot exists: latch the lowest-index free slot, go to REQ.
    - If no slot is free: the spawn is skipped; go to IDLE.
  - Otherwise go to IDLE.
- REQ: rand_new=1 for this cycle; capture rand_data into x_lat at the clock edge; go to WRITE.
- WRITE: latched slot gets valid=1, x=x_lat, y=START_Y; spawn_count increments (wraps 255->0); go to IDLE.
- Frame processing latency: NUM_SLOTS+1 cycles, or NUM_SLOTS+3 cycles with a spawn.
- frame_tick while busy: sets tick_pending; only one is held, further ticks while pending are dropped.
- hit_valid: accepted in any state.
  - Clears valid of hit_slot on the next edge.
  - Takes priority over a simultaneous MOVE update of the same slot; that slot gets no miss.
  - A hit on an invalid slot is ignored.
  - A hit on the latched slot during REQ/WRITE does not block the write; the new obstacle wins.
- Read port: purely combinational from the table; reflects state after the last edge.
- reset_n asserted mid-operation: everything returns to reset values immediately; the in-flight spawn is lost.
- Only one miss pulse per cycle is possible, since MOVE handles one slot per cycle.

Decomposition:
- Shared game package holds:
  - the FSM state encoding
  - the SCREEN_H and START_Y constants, shared with the renderer
  - the slot index width function
- One natural sub-module, obstacle_table: slot register array with one write port (MOVE/WRITE), a hit-clear port and a combinational read port. The FSM stays in obstacle_spawner.

Test Plan:
- Reset, then 60 frame_ticks with rand_data=10'd200 → rand_new pulses once after the 60th tick; slot 0 valid, x=200, y=0; spawn_count=1.
- After the spawn, 10 further ticks → rd_y for slot 0 = 40; no miss.
- Obstacle at y=764, one tick with SPEED=4, SCREEN_H=768 → valid cleared, miss pulses exactly one cycle.
- All 4 slots full at the spawn point → no rand_new, spawn_count unchanged, interval counter reloads to 60.
- hit_valid with hit_slot=0 in the same cycle MOVE processes slot 0 → slot 0 invalid, y not updated, no miss.
- Two frame_ticks 1 cycle apart plus a third while pending → exactly two MOVE passes; then assert reset_n=0 during REQ → rand_new drops immediately and all slots are invalid.
